lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
- Load/store sequencer between the core's memory stage and a byte-wide, synchronous-read data RAM.
- Accepts one load or store per request, with width selected by func3.
- Splits each request into 1, 2 or 4 little-endian byte accesses, assembles load data, sign- or zero-extends it, and returns a done pulse.
- Deasserts ready while busy, so the core stalls on it.

Parameters:
- ADDR_W, 8, byte-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request valid; sampled only when ready=1
- MemRead  in  1  load request
- MemWrite  in  1  store request
- func3  in  3  access type: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010
- addr  in  ADDR_W  byte start address
- data_in  in  32  store data; bits used are LSB-first
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on an illegal request
- data_out  out  32  extended load result; valid with done, held until the next done
- mem_addr  out  ADDR_W  byte RAM address, registered
- mem_re  out  1  byte RAM read enable, registered
- mem_we  out  1  byte RAM write enable, registered
- mem_wdata  out  8  byte RAM write data, registered
- mem_rdata  in  8  byte RAM read data; valid the cycle after mem_re is high

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, ready=1.
  - done, err, mem_re, mem_we = 0.
  - data_out, mem_addr, mem_wdata, byte counter, assembly register = 0.
  - An in-flight access is aborted; partially written bytes remain in RAM.
- Acceptance: on an edge with req=1 and ready=1, the block latches addr, func3, data_in and direction. ready drops the next cycle.
- Byte count N:
  - 1 for LB/LBU/SB.
  - 2 for LH/LHU/SH.
  - 4 for LW/SW.
- Illegal requests:
  - MemRead=MemWrite=1, MemRead=MemWrite=0, load func3 in {011,110,111}, store func3 >= 011.
  - Go to DONE with err=1, data_out=0, no mem_re/mem_we.
  - done/err are high the cycle after acceptance.
- States: IDLE, LOAD, LCAP, STORE, DONE.
- LOAD:
  - For k=0..N-1, drives mem_re=1 and mem_addr=addr+k, one byte per cycle.
  - The byte returned in cycle k+1 goes into assembly bits [8k+7:8k].
  - After issuing the last byte, moves to LCAP to capture it. mem_re=0 in LCAP.
  - Then DONE: data_out is updated and done=1.
- Load timing: done is high in cycle N+2 after the acceptance edge (cycle 1 is the first issue cycle).
- Load extension:
  - LB/LH: sign-extend from bit 7 or bit 15.
  - LBU/LHU: zero-extend.
  - LW: no extension.
- STORE:
  - For k=0..N-1, drives mem_we=1, mem_addr=addr+k, mem_wdata=data_in[8k+7:8k].
  - Then DONE.
  - Store timing: done is high in cycle N+1 after acceptance.
  - data_out is unchanged by stores.
- DONE: lasts one cycle and returns to IDLE. ready=1 the following cycle.
- Misaligned addresses are legal and handled byte-wise.
- Address wrap: addr+k wraps mod 2^ADDR_W (e.g. LW at 0xFE reads FE, FF, 00, 01).
- mem_re and mem_we are never both high.
- req inputs while ready=0 are ignored.

Decomposition:
- Shared package/defines:
  - F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - State encodings.
  - Byte-count function from func3.
- One natural sub-module, load_extend: combinational {func3, 32-bit assembled word} -> extended data_out.

Test Plan:
1. Preload RAM[0x10..0x13]=78,56,34,12; LW at 0x10 -> mem_re for 4 cycles at 10,11,12,13; done 6 cycles after acceptance; data_out=0x12345678; err=0.
2. RAM[0x20]=0x80: LB at 0x20 -> data_out=0xFFFFFF80; LBU at 0x20 -> 0x00000080; each done 3 cycles after acceptance.
3. SW data_in=0xDEADBEEF at 0xFE -> writes FE=EF, FF=BE, 00=AD, 01=DE on consecutive cycles; done 5 cycles after acceptance; then LW at 0xFE returns 0xDEADBEEF.
4. SH data_in=0x0000A5C3 at 0x31 (misaligned) -> RAM[31]=C3, RAM[32]=A5; LH at 0x31 -> 0xFFFFA5C3; LHU -> 0x0000A5C3.
5. MemRead=MemWrite=1, and separately a load with func3=011 -> done=err=1 one cycle after acceptance; no mem_re/mem_we; data_out=0.
6. rst_n low during cycle 2 of an SW -> immediately ready=1 and mem_we=0; only bytes 0-1 are written; a subsequent LB completes normally.

Source files
------------

// File: rtl/lsu_byte_sequencer_pkg.sv
// ============================================================================
// Module   : lsu_byte_sequencer_pkg
// Brief    : Shared func3 codes, FSM state encoding and request helpers for
//            the byte-wide load/store sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_byte_sequencer_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LCAP  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Width is carried by the low two func3 bits for both loads and stores.
    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic req_legal(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] f3);
        if (rd && !wr) begin
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        if (wr && !rd) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_sequencer_load_extend.sv
// ============================================================================
// Module   : lsu_byte_sequencer_load_extend
// Brief    : Sign/zero extension of an assembled little-endian load word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_sequencer_load_extend
    import lsu_byte_sequencer_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    always_comb begin
        case (i_func3)
            F3_LB:   o_data = {{24{i_word[7]}}, i_word[7:0]};
            F3_LH:   o_data = {{16{i_word[15]}}, i_word[15:0]};
            F3_LBU:  o_data = {24'd0, i_word[7:0]};
            F3_LHU:  o_data = {16'd0, i_word[15:0]};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_byte_sequencer.sv
// ============================================================================
// Module   : lsu_byte_sequencer
// Brief    : Splits core loads/stores into little-endian byte accesses to a
//            synchronous-read byte RAM; assembles and extends load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_sequencer
    import lsu_byte_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       data_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e              r_state_q,     w_state_d;
    logic [1:0]          r_cnt_q,       w_cnt_d;
    logic [1:0]          r_rd_idx_q,    w_rd_idx_d;
    logic                r_rd_pend_q,   w_rd_pend_d;
    logic [ADDR_W-1:0]   r_addr_q,      w_addr_d;
    logic [2:0]          r_func3_q,     w_func3_d;
    logic [31:0]         r_wdata_q,     w_wdata_d;
    logic [31:0]         r_asm_q,       w_asm_d;
    logic [31:0]         r_data_out_q,  w_data_out_d;
    logic                r_ready_q,     w_ready_d;
    logic                r_done_q,      w_done_d;
    logic                r_err_q,       w_err_d;
    logic [ADDR_W-1:0]   r_mem_addr_q,  w_mem_addr_d;
    logic                r_mem_re_q,    w_mem_re_d;
    logic                r_mem_we_q,    w_mem_we_d;
    logic [7:0]          r_mem_wdata_q, w_mem_wdata_d;

    logic [31:0]         w_asm_cap;
    logic [1:0]          w_rd_idx_cap;
    logic [31:0]         w_ext;
    logic [1:0]          w_cnt_inc;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr_next;

    // Read data lags mem_re by one cycle; r_rd_pend_q marks that cycle.
    always_comb begin
        w_asm_cap    = r_asm_q;
        w_rd_idx_cap = r_rd_idx_q;
        if (r_rd_pend_q) begin
            w_asm_cap[{r_rd_idx_q, 3'b000} +: 8] = mem_rdata;
            w_rd_idx_cap                         = r_rd_idx_q + 2'd1;
        end
    end

    lsu_byte_sequencer_load_extend u_load_extend (
        .i_func3 (r_func3_q),
        .i_word  (w_asm_cap),
        .o_data  (w_ext)
    );

    assign w_cnt_inc   = r_cnt_q + 2'd1;
    assign w_last      = ({1'b0, r_cnt_q} == (byte_count(r_func3_q) - 3'd1));
    assign w_addr_next = r_addr_q + ADDR_W'(w_cnt_inc);

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rd_idx_d    = w_rd_idx_cap;
        w_rd_pend_d   = r_mem_re_q;
        w_addr_d      = r_addr_q;
        w_func3_d     = r_func3_q;
        w_wdata_d     = r_wdata_q;
        w_asm_d       = w_asm_cap;
        w_data_out_d  = r_data_out_q;
        w_ready_d     = r_ready_q;
        w_done_d      = 1'b0;
        w_err_d       = 1'b0;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_re_d    = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_wdata_d = r_mem_wdata_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req) begin
                    w_addr_d   = addr;
                    w_func3_d  = func3;
                    w_wdata_d  = data_in;
                    w_asm_d    = 32'd0;
                    w_rd_idx_d = 2'd0;
                    w_cnt_d    = 2'd0;
                    w_ready_d  = 1'b0;
                    if (!req_legal(MemRead, MemWrite, func3)) begin
                        w_state_d    = ST_DONE;
                        w_done_d     = 1'b1;
                        w_err_d      = 1'b1;
                        w_data_out_d = 32'd0;
                    end else if (MemRead) begin
                        w_state_d    = ST_LOAD;
                        w_mem_re_d   = 1'b1;
                        w_mem_addr_d = addr;
                    end else begin
                        w_state_d     = ST_STORE;
                        w_mem_we_d    = 1'b1;
                        w_mem_addr_d  = addr;
                        w_mem_wdata_d = data_in[7:0];
                    end
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_state_d = ST_LCAP;
                end else begin
                    w_cnt_d      = w_cnt_inc;
                    w_mem_re_d   = 1'b1;
                    w_mem_addr_d = w_addr_next;
                end
            end
            ST_LCAP: begin
                w_state_d    = ST_DONE;
                w_done_d     = 1'b1;
                w_data_out_d = w_ext;
            end
            ST_STORE: begin
                if (w_last) begin
                    w_state_d = ST_DONE;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d       = w_cnt_inc;
                    w_mem_we_d    = 1'b1;
                    w_mem_addr_d  = w_addr_next;
                    w_mem_wdata_d = r_wdata_q[{w_cnt_inc, 3'b000} +: 8];
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_ready_d = 1'b1;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= 2'd0;
            r_rd_idx_q    <= 2'd0;
            r_rd_pend_q   <= 1'b0;
            r_addr_q      <= '0;
            r_func3_q     <= 3'd0;
            r_wdata_q     <= 32'd0;
            r_asm_q       <= 32'd0;
            r_data_out_q  <= 32'd0;
            r_ready_q     <= 1'b1;
            r_done_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_re_q    <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_wdata_q <= 8'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rd_idx_q    <= w_rd_idx_d;
            r_rd_pend_q   <= w_rd_pend_d;
            r_addr_q      <= w_addr_d;
            r_func3_q     <= w_func3_d;
            r_wdata_q     <= w_wdata_d;
            r_asm_q       <= w_asm_d;
            r_data_out_q  <= w_data_out_d;
            r_ready_q     <= w_ready_d;
            r_done_q      <= w_done_d;
            r_err_q       <= w_err_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_re_q    <= w_mem_re_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_wdata_q <= w_mem_wdata_d;
        end
    end

    assign ready     = r_ready_q;
    assign done      = r_done_q;
    assign err       = r_err_q;
    assign data_out  = r_data_out_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_re    = r_mem_re_q;
    assign mem_we    = r_mem_we_q;
    assign mem_wdata = r_mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_sequencer.sv
// ============================================================================
// Module   : tb_lsu_byte_sequencer
// Brief    : Directed scoreboard bench for lsu_byte_sequencer with a byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_sequencer;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wd;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] data_in = 32'd0;
    logic        ready, done, err, mem_re, mem_we;
    logic [31:0] data_out;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  ram [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'd0;
    logic [7:0]  bd_data = 8'd0;

    acc_t        acc_q[$];
    res_t        res_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] last_data = 32'd0;

    lsu_byte_sequencer #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .func3     (func3),
        .addr      (addr),
        .data_in   (data_in),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .data_out  (data_out),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Cycle counter; acceptance edge recorded so latency is measured in the DUT's cycle terms.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && req && ready) acc_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re || mem_we) begin
                chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
                chk("access_expected", {31'd0, acc_q.size() != 0}, 32'd1);
                if (acc_q.size() != 0) begin
                    acc_t a;
                    a = acc_q.pop_front();
                    chk("acc_we", {31'd0, mem_we}, {31'd0, a.we});
                    chk("acc_addr", {24'd0, mem_addr}, {24'd0, a.addr});
                    if (a.we) chk("acc_wdata", {24'd0, mem_wdata}, {24'd0, a.wd});
                end
            end
            if (done) begin
                chk("done_expected", {31'd0, res_q.size() != 0}, 32'd1);
                if (res_q.size() != 0) begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("data_out", data_out, r.data);
                    chk("err", {31'd0, err}, {31'd0, r.err});
                    chk("latency", cyc - acc_cyc + 1, r.lat);
                end
            end
        end
    end

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input bit junk);
        bit   legal;
        int   n;
        int   t;
        acc_t e;
        res_t r;
        legal = (rd && !wr) ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
                (wr && !rd) ? (f3 inside {3'b000, 3'b001, 3'b010}) : 1'b0;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                e.we   = wr;
                e.addr = a + 8'(k);
                e.wd   = d[8*k +: 8];
                acc_q.push_back(e);
            end
            r.data = rd ? exp_data : last_data;
            r.err  = 1'b0;
            r.lat  = rd ? n + 2 : n + 1;
        end else begin
            r.data = 32'd0;
            r.err  = 1'b1;
            r.lat  = 1;
        end
        last_data = r.data;
        res_q.push_back(r);

        wait_ready();
        req = 1'b1; MemRead = rd; MemWrite = wr; func3 = f3; addr = a; data_in = d;
        @(negedge clk);
        if (junk) begin
            // Busy-time request that must be ignored.
            MemRead = 1'b0; MemWrite = 1'b1; func3 = 3'b000; addr = 8'h77; data_in = 32'hFF;
            repeat (2) @(negedge clk);
        end
        req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        t = 0;
        while (res_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", res_q.size(), 0);
    endtask

    initial begin
        acc_t e;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        bd_write(8'h10, 8'h78); bd_write(8'h11, 8'h56);
        bd_write(8'h12, 8'h34); bd_write(8'h13, 8'h12);
        bd_write(8'h20, 8'h80);
        bd_write(8'h42, 8'hAA); bd_write(8'h43, 8'hAA);

        do_req(1, 0, 3'b010, 8'h10, 32'd0, 32'h12345678, 1);
        do_req(1, 0, 3'b000, 8'h20, 32'd0, 32'hFFFFFF80, 0);
        do_req(1, 0, 3'b100, 8'h20, 32'd0, 32'h00000080, 0);

        do_req(0, 1, 3'b010, 8'hFE, 32'hDEADBEEF, 32'd0, 0);
        chk("ram_fe", {24'd0, ram[8'hFE]}, 32'hEF);
        chk("ram_01", {24'd0, ram[8'h01]}, 32'hDE);
        do_req(1, 0, 3'b010, 8'hFE, 32'd0, 32'hDEADBEEF, 0);

        do_req(0, 1, 3'b001, 8'h31, 32'h0000A5C3, 32'd0, 0);
        chk("ram_31", {24'd0, ram[8'h31]}, 32'hC3);
        chk("ram_32", {24'd0, ram[8'h32]}, 32'hA5);
        chk("ram_33", {24'd0, ram[8'h33]}, 32'h00);
        do_req(1, 0, 3'b001, 8'h31, 32'd0, 32'hFFFFA5C3, 0);
        do_req(1, 0, 3'b101, 8'h31, 32'd0, 32'h0000A5C3, 0);

        do_req(1, 1, 3'b010, 8'h10, 32'h1, 32'd0, 0);
        do_req(1, 0, 3'b011, 8'h10, 32'd0, 32'd0, 0);
        do_req(0, 1, 3'b100, 8'h50, 32'h55, 32'd0, 0);
        do_req(0, 0, 3'b000, 8'h50, 32'h55, 32'd0, 0);
        chk("ram_50_untouched", {24'd0, ram[8'h50]}, 32'h00);
        do_req(1, 0, 3'b000, 8'h12, 32'd0, 32'h00000034, 0);

        // Reset in the middle of a word store: only the first two bytes land.
        wait_ready();
        for (int k = 0; k < 2; k++) begin
            e.we = 1'b1; e.addr = 8'h40 + 8'(k); e.wd = (k == 0) ? 8'h44 : 8'h33;
            acc_q.push_back(e);
        end
        req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; func3 = 3'b010;
        addr = 8'h40; data_in = 32'h11223344;
        @(posedge clk);
        #1 req = 1'b0; MemWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_data = 32'd0;
        chk("abort_ram_40", {24'd0, ram[8'h40]}, 32'h44);
        chk("abort_ram_41", {24'd0, ram[8'h41]}, 32'h33);
        chk("abort_ram_42", {24'd0, ram[8'h42]}, 32'hAA);
        chk("abort_ram_43", {24'd0, ram[8'h43]}, 32'hAA);
        do_req(1, 0, 3'b000, 8'h41, 32'd0, 32'h00000033, 0);

        repeat (3) @(negedge clk);
        chk("acc_q_empty", acc_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
